apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB3 memory-mapped slave: the next generation of the per-slave memory blocks behind the APB bridge. It replaces the fixed 8-bit, 64-entry, zero-wait slaves with one block configurable in data width, address width, depth and wait-state count. It adds PSLVERR for out-of-range addresses and is a registered setup/access state machine, so writes commit only on a clock edge. One instance sits on each PSELx line of the APB interconnect; PRDATA feeds the interconnect read mux.

## Interface

- DATA_WIDTH, 8: width of PWDATA, PRDATA and each memory word.
- ADDR_WIDTH, 8: width of PADDR, interpreted as a word index (no byte addressing).
- DEPTH, 64: number of memory words; must satisfy 1 <= DEPTH <= 2^ADDR_WIDTH.
- WAIT_STATES, 0: access-phase cycles with PREADY low before completion; legal range 0..15.
- PCLK  in  1  single clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select from the interconnect.
- PENABLE  in  1  APB access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  word address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer-complete / wait-state control.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation

- State register: IDLE and ACCESS. Wait counter wcnt is 4 bits. Memory is a DEPTH x DATA_WIDTH register array.
- Reset (PRESETn=0, asynchronous): state=IDLE, wcnt=0, every memory word=0. PREADY=0, PSLVERR=0, PRDATA=0 while reset is held.
- IDLE: a rising edge with PSEL=1, PENABLE=0 (setup phase) moves the block to ACCESS and sets wcnt=0. PSEL=1 with PENABLE=1 in IDLE is a protocol violation: it is ignored, PREADY stays 0 and nothing is written.
- ACCESS with PSEL=1, PENABLE=1 and wcnt<WAIT_STATES: PREADY=0 and wcnt increments on the edge.
- ACCESS with PSEL=1, PENABLE=1 and wcnt==WAIT_STATES: PREADY=1 and the state returns to IDLE on the edge.
- ACCESS with PSEL=0 (master abort): return to IDLE and set wcnt=0. No write occurs.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (wcnt==WAIT_STATES). This is combinational from registered state.
- Address check: err = (PADDR >= DEPTH). PSLVERR = PREADY & err.
- Write: on the edge where PREADY=1, PWRITE=1 and err=0, mem[PADDR] <= PWDATA. An erroring write leaves memory unchanged.
- Read: PRDATA = mem[PADDR] when PREADY=1, PWRITE=0 and err=0. PRDATA is 0 in every other cycle, including erroring reads, which keeps the interconnect OR-mux clean.
- Memory index uses the low clog2(DEPTH) bits of PADDR, and only after the range check has passed.
- Control, address and data are sampled in the completing cycle; the master holds them stable through the access phase per APB.

## Timing

- WAIT_STATES=0: setup in cycle T, access in T+1 with PREADY=1. The write commits at the end of T+1, and read data is valid during T+1.
- WAIT_STATES=N: PREADY is low in access cycles T+1..T+N and high in T+1+N. A transfer occupies N+2 cycles.
- Back-to-back: the setup of the next transfer may occur in the cycle right after completion. IDLE accepts it, so there is no dead cycle.
- Read-after-write to the same address in the next transfer returns the new data.
- Reset asserted mid-access: the state drops immediately to IDLE, PREADY goes to 0 asynchronously, and memory is zeroed. A write pending in the reset cycle is lost.
- Reset release is synchronous to the first PCLK edge with PRESETn=1. The first legal setup may occur in that cycle.

## Test plan

- Defaults, WAIT_STATES=0: write 0xA5 to addr 0x10, then read addr 0x10. Each access phase has PREADY=1 in its first cycle, PSLVERR=0, and the read returns PRDATA=0xA5.
- WAIT_STATES=3: write 0x3C to addr 5, then read it back. PREADY is low for exactly 3 access cycles and high on the 4th. The read returns 0x3C. Memory is unchanged until the PREADY=1 edge.
- Out of range, DEPTH=64: write 0xFF to addr 0x40, then read addr 0x40. PREADY=1 with PSLVERR=1 and PRDATA=0 on both. A follow-up read of addr 0x00 returns 0x00 (no aliasing write).
- Back-to-back writes to addrs 1, 2, 3 (data 0x11, 0x22, 0x33) with no idle cycles, then reads of all three. Returns 0x11, 0x22, 0x33. Every access completes after the configured latency.
- Abort and violation: drop PSEL during a wait state with WAIT_STATES=2, and separately drive PSEL=PENABLE=1 from IDLE with no setup. No memory change and PREADY=0 in both cases. The next legal transfer completes normally.
- Reset mid-transfer: assert PRESETn=0 during a WAIT_STATES=2 write after writing 0x77 to addr 9. PREADY drops immediately. After release, a read of addr 9 returns 0x00.

Source files
------------

// File: rtl/apb_mem_slave_if.sv
// APB3 completer-side bus bundle: master drives select/strobe/address/data,
// slave returns read data, ready and error.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 register-array slave: setup + (WAIT_STATES+1) access cycles per transfer.
// Wait states via PREADY low; out-of-range word addresses complete with PSLVERR.
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_mem_slave_if.slave        bus
);

  localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wcnt, wcnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  err;
  logic                  pready;
  logic [IDX_W-1:0]      idx;

  // Range check done at 32 bits so DEPTH == 2^ADDR_WIDTH never overflows.
  assign err = 32'(bus.PADDR) >= 32'(DEPTH);
  assign idx = bus.PADDR[IDX_W-1:0];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    pready    = 1'b0;
    case (state)
      IDLE: begin
        // PSEL with PENABLE already high and no setup phase is ignored.
        if (bus.PSEL && !bus.PENABLE) begin
          state_nxt = ACCESS;
          wcnt_nxt  = 4'd0;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end else if (bus.PENABLE) begin
          if (wcnt == WS) begin
            pready    = 1'b1;
            state_nxt = IDLE;
          end else begin
            wcnt_nxt = wcnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pready && bus.PWRITE && !err) begin
      mem[idx] <= bus.PWDATA;
    end
  end

  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pready & err;
  // Zero outside a good read completion keeps the interconnect OR-mux clean.
  assign bus.PRDATA  = (pready && !bus.PWRITE && !err) ? mem[idx] : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench: three slaves (WAIT_STATES 0, 2, 3) on a shared clock and reset,
// exercised one at a time through an index-selected driver.
module tb_apb_mem_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Index 0: WAIT_STATES=0, 1: WAIT_STATES=2, 2: WAIT_STATES=3
  logic       psel    [3];
  logic       penable [3];
  logic       pwrite  [3];
  logic [7:0] paddr   [3];
  logic [7:0] pwdata  [3];
  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];

  apb_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if_ws0 ();
  apb_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if_ws2 ();
  apb_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if_ws3 ();

  assign if_ws0.PSEL    = psel[0];
  assign if_ws0.PENABLE = penable[0];
  assign if_ws0.PWRITE  = pwrite[0];
  assign if_ws0.PADDR   = paddr[0];
  assign if_ws0.PWDATA  = pwdata[0];
  assign prdata[0]      = if_ws0.PRDATA;
  assign pready[0]      = if_ws0.PREADY;
  assign pslverr[0]     = if_ws0.PSLVERR;

  assign if_ws2.PSEL    = psel[1];
  assign if_ws2.PENABLE = penable[1];
  assign if_ws2.PWRITE  = pwrite[1];
  assign if_ws2.PADDR   = paddr[1];
  assign if_ws2.PWDATA  = pwdata[1];
  assign prdata[1]      = if_ws2.PRDATA;
  assign pready[1]      = if_ws2.PREADY;
  assign pslverr[1]     = if_ws2.PSLVERR;

  assign if_ws3.PSEL    = psel[2];
  assign if_ws3.PENABLE = penable[2];
  assign if_ws3.PWRITE  = pwrite[2];
  assign if_ws3.PADDR   = paddr[2];
  assign if_ws3.PWDATA  = pwdata[2];
  assign prdata[2]      = if_ws3.PRDATA;
  assign pready[2]      = if_ws3.PREADY;
  assign pslverr[2]     = if_ws3.PSLVERR;

  apb_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .bus(if_ws0.slave));
  apb_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(2)) u_ws2 (
    .PCLK(clk), .PRESETn(rst_n), .bus(if_ws2.slave));
  apb_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(rst_n), .bus(if_ws3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer on slave k. Entered just after a rising edge; returns just
  // after the completing edge with PSEL low, so a following call is back-to-back.
  task automatic xfer(input int k, input logic wr, input logic [7:0] addr,
                      input logic [7:0] data, output logic [7:0] rd,
                      output logic er, output int waits, output logic done);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
    paddr[k] = addr; pwdata[k] = data;
    rd = 8'h00; er = 1'b0; waits = 0; done = 1'b0;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pready[k]) begin
        done = 1'b1;
        rd   = prdata[k];
        er   = pslverr[k];
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       er, done;
    int         waits;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = 8'h00; pwdata[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pready", 32'(pready[0]), 32'd0);
    chk("reset_pslverr", 32'(pslverr[0]), 32'd0);
    chk("reset_prdata", 32'(prdata[0]), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero wait states: write then read 0x10
    xfer(0, 1'b1, 8'h10, 8'hA5, rd, er, waits, done);
    chk("ws0_wr_done", 32'(done), 32'd1);
    chk("ws0_wr_waits", 32'(waits), 32'd0);
    chk("ws0_wr_err", 32'(er), 32'd0);
    chk("ws0_wr_prdata_zero", 32'(rd), 32'h00);
    xfer(0, 1'b0, 8'h10, 8'h00, rd, er, waits, done);
    chk("ws0_rd_waits", 32'(waits), 32'd0);
    chk("ws0_rd_err", 32'(er), 32'd0);
    chk("ws0_rd_data", 32'(rd), 32'hA5);

    // Three wait states: write then read addr 5
    xfer(2, 1'b1, 8'h05, 8'h3C, rd, er, waits, done);
    chk("ws3_wr_done", 32'(done), 32'd1);
    chk("ws3_wr_waits", 32'(waits), 32'd3);
    xfer(2, 1'b0, 8'h05, 8'h00, rd, er, waits, done);
    chk("ws3_rd_waits", 32'(waits), 32'd3);
    chk("ws3_rd_data", 32'(rd), 32'h3C);

    // Out of range address 0x40 on a 64-deep slave
    xfer(0, 1'b1, 8'h40, 8'hFF, rd, er, waits, done);
    chk("oor_wr_done", 32'(done), 32'd1);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_prdata", 32'(rd), 32'h00);
    xfer(0, 1'b0, 8'h40, 8'h00, rd, er, waits, done);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_prdata", 32'(rd), 32'h00);
    xfer(0, 1'b0, 8'h00, 8'h00, rd, er, waits, done);
    chk("oor_alias_err", 32'(er), 32'd0);
    chk("oor_alias_data", 32'(rd), 32'h00);

    // Back-to-back writes then reads, no idle cycles in between
    xfer(0, 1'b1, 8'h01, 8'h11, rd, er, waits, done);
    chk("b2b_wr1_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 8'h02, 8'h22, rd, er, waits, done);
    chk("b2b_wr2_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 8'h03, 8'h33, rd, er, waits, done);
    chk("b2b_wr3_waits", 32'(waits), 32'd0);
    xfer(0, 1'b0, 8'h01, 8'h00, rd, er, waits, done);
    chk("b2b_rd1", 32'(rd), 32'h11);
    xfer(0, 1'b0, 8'h02, 8'h00, rd, er, waits, done);
    chk("b2b_rd2", 32'(rd), 32'h22);
    xfer(0, 1'b0, 8'h03, 8'h00, rd, er, waits, done);
    chk("b2b_rd3", 32'(rd), 32'h33);
    chk("b2b_rd3_waits", 32'(waits), 32'd0);

    // Abort: drop PSEL during a wait state of a WAIT_STATES=2 write
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h04; pwdata[1] = 8'h5A;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    chk("abort_wait_pready", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    chk("abort_idle_pready", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h04, 8'h00, rd, er, waits, done);
    chk("abort_rd_waits", 32'(waits), 32'd2);
    chk("abort_rd_data", 32'(rd), 32'h00);

    // Protocol violation: PSEL and PENABLE together from IDLE
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 8'h07; pwdata[0] = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("viol_pready", 32'(pready[0]), 32'd0);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 1'b0, 8'h07, 8'h00, rd, er, waits, done);
    chk("viol_rd_data", 32'(rd), 32'h00);
    xfer(0, 1'b1, 8'h07, 8'hEE, rd, er, waits, done);
    chk("viol_next_wr_waits", 32'(waits), 32'd0);
    xfer(0, 1'b0, 8'h07, 8'h00, rd, er, waits, done);
    chk("viol_next_rd_data", 32'(rd), 32'hEE);

    // Reset during the completing cycle of a WAIT_STATES=2 write
    xfer(1, 1'b1, 8'h09, 8'h77, rd, er, waits, done);
    chk("rst_pre_wr_waits", 32'(waits), 32'd2);
    xfer(1, 1'b0, 8'h09, 8'h00, rd, er, waits, done);
    chk("rst_pre_rd_data", 32'(rd), 32'h77);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h09; pwdata[1] = 8'h99;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pending_pready", 32'(pready[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pready", 32'(pready[1]), 32'd0);
    chk("rst_async_prdata", 32'(prdata[1]), 32'h00);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 1'b0, 8'h09, 8'h00, rd, er, waits, done);
    chk("rst_post_rd_done", 32'(done), 32'd1);
    chk("rst_post_rd_data", 32'(rd), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
